// File: rtl/rgb_hue_fader_pkg.sv
// Shared types and helpers for the RGB hue fader: hue sectors, per-channel
// duty selection and the sector-to-selection table.
package rgb_pkg;

  typedef enum logic [2:0] {
    HUE_RED     = 3'd0,
    HUE_YELLOW  = 3'd1,
    HUE_GREEN   = 3'd2,
    HUE_CYAN    = 3'd3,
    HUE_BLUE    = 3'd4,
    HUE_MAGENTA = 3'd5
  } hue_t;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_FULL = 2'd1,
    SEL_RISE = 2'd2,
    SEL_FALL = 2'd3
  } duty_sel_t;

  typedef struct packed {
    duty_sel_t r;
    duty_sel_t g;
    duty_sel_t b;
  } rgb_sel_t;

  // Walk the hue wheel one sector forward, MAGENTA wrapping back to RED.
  function automatic hue_t next_hue(input hue_t h);
    hue_t n;
    case (h)
      HUE_RED:     n = HUE_YELLOW;
      HUE_YELLOW:  n = HUE_GREEN;
      HUE_GREEN:   n = HUE_CYAN;
      HUE_CYAN:    n = HUE_BLUE;
      HUE_BLUE:    n = HUE_MAGENTA;
      default:     n = HUE_RED;
    endcase
    return n;
  endfunction

  // Per-channel duty selection for a sector; mode 1 cross-fades between
  // neighbouring colours, mode 0 shows only the sector's named colour.
  function automatic rgb_sel_t duty_sel(input hue_t h, input logic mode);
    rgb_sel_t s;
    if (mode) begin
      case (h)
        HUE_RED:     s = '{SEL_FULL, SEL_RISE, SEL_ZERO};
        HUE_YELLOW:  s = '{SEL_FALL, SEL_FULL, SEL_ZERO};
        HUE_GREEN:   s = '{SEL_ZERO, SEL_FULL, SEL_RISE};
        HUE_CYAN:    s = '{SEL_ZERO, SEL_FALL, SEL_FULL};
        HUE_BLUE:    s = '{SEL_RISE, SEL_ZERO, SEL_FULL};
        default:     s = '{SEL_FULL, SEL_ZERO, SEL_FALL};
      endcase
    end else begin
      case (h)
        HUE_RED:     s = '{SEL_FULL, SEL_ZERO, SEL_ZERO};
        HUE_YELLOW:  s = '{SEL_FULL, SEL_FULL, SEL_ZERO};
        HUE_GREEN:   s = '{SEL_ZERO, SEL_FULL, SEL_ZERO};
        HUE_CYAN:    s = '{SEL_ZERO, SEL_FULL, SEL_FULL};
        HUE_BLUE:    s = '{SEL_ZERO, SEL_ZERO, SEL_FULL};
        default:     s = '{SEL_FULL, SEL_ZERO, SEL_FULL};
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/rgb_hue_fader_pwm_channel.sv
// One LED channel: compares the shared PWM count against this channel's
// duty and registers the resulting pin level with the requested polarity.
module pwm_channel #(
  parameter int unsigned PWM_BITS   = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS:0]   i_duty,
  input  logic [PWM_BITS-1:0] i_pwm,
  input  logic                i_rst_level,
  output logic                o_pin
);

  logic w_lit;
  logic r_pin;

  // Duty of 2^N always exceeds the N-bit count, so FULL is lit every clock.
  assign w_lit = ({1'b0, i_pwm} < i_duty);

  // Pin register; reset level is tied off to a constant by the parent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin <= i_rst_level;
    end else begin
      r_pin <= w_lit ^ ACTIVE_LOW;
    end
  end

  assign o_pin = r_pin;

endmodule

// File: rtl/rgb_hue_fader.sv
// Tri-colour LED hue walker: prescaler, fade level, hue sector FSM and a
// free-running PWM counter feeding three registered PWM channels.
module rgb_hue_fader
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned STEP_INTERVAL = 2000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode,
  input  logic pause,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B
);

  localparam int unsigned       PRE_W     = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_INTERVAL - 1);
  localparam logic [PWM_BITS:0] DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic              PIN_ON    = ~ACTIVE_LOW;
  localparam logic              PIN_OFF   = ACTIVE_LOW;

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_lvl;
  logic [PWM_BITS-1:0] r_pwm;
  hue_t                r_hue;
  hue_t                w_hue_next;
  logic                w_step;
  logic                w_wrap;
  rgb_sel_t            w_sel;
  logic [PWM_BITS:0]   w_duty_r;
  logic [PWM_BITS:0]   w_duty_g;
  logic [PWM_BITS:0]   w_duty_b;

  function automatic logic [PWM_BITS:0] sel_duty(input duty_sel_t s,
                                                 input logic [PWM_BITS-1:0] l);
    logic [PWM_BITS:0] d;
    case (s)
      SEL_ZERO: d = '0;
      SEL_FULL: d = DUTY_FULL;
      SEL_RISE: d = {1'b0, l};
      default:  d = DUTY_FULL - {1'b0, l};
    endcase
    return d;
  endfunction

  // Pause suppresses the level step, so a coincident wrap is also held off.
  assign w_step = !pause && (r_pre == PRE_LAST);
  assign w_wrap = w_step && (r_lvl == '1);

  // Prescaler and fade level counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_lvl <= '0;
    end else if (!pause) begin
      if (w_step) begin
        r_pre <= '0;
        r_lvl <= r_lvl + PWM_BITS'(1);
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  // Free-running PWM period counter; ignores pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
    end
  end

  // Hue sector state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hue <= HUE_RED;
    end else begin
      r_hue <= w_hue_next;
    end
  end

  // Sector advances only when the fade level wraps.
  always_comb begin
    w_hue_next = r_hue;
    if (w_wrap) begin
      w_hue_next = next_hue(r_hue);
    end
  end

  // Sector and mode select each channel's duty from the current level.
  always_comb begin
    w_sel    = duty_sel(r_hue, mode);
    w_duty_r = sel_duty(w_sel.r, r_lvl);
    w_duty_g = sel_duty(w_sel.g, r_lvl);
    w_duty_b = sel_duty(w_sel.b, r_lvl);
  end

  pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_duty      (w_duty_r),
    .i_pwm       (r_pwm),
    .i_rst_level (PIN_ON),
    .o_pin       (RGB_R)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_duty      (w_duty_g),
    .i_pwm       (r_pwm),
    .i_rst_level (PIN_OFF),
    .o_pin       (RGB_G)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_duty      (w_duty_b),
    .i_pwm       (r_pwm),
    .i_rst_level (PIN_OFF),
    .o_pin       (RGB_B)
  );

endmodule

// File: tb/tb_rgb_hue_fader.sv
// Scoreboard bench for rgb_hue_fader with PWM_BITS=2, STEP_INTERVAL=3,
// ACTIVE_LOW=1. Expected pins {R,G,B} are queued per clock by the stimulus
// and popped/compared on the falling edge by an independent monitor.
module tb_rgb_hue_fader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mode = 1'b1;
  logic pause = 1'b0;
  logic RGB_R, RGB_G, RGB_B;

  rgb_hue_fader #(
    .PWM_BITS      (2),
    .STEP_INTERVAL (3),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .pause (pause),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] exp;
  } sb_t;

  sb_t q[$];
  int checks = 0;
  int failures = 0;
  int e = 0;   // clock edges since reset release (PWM count source)
  int c = 0;   // non-paused edges since reset release (progression source)

  // Hand-derived {R,G,B} pin levels (active low) for each sector's named
  // colour: RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA.
  logic [2:0] named [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

  function automatic int smooth_duty(int hue, int ch, int lvl);
    int t[3];
    case (hue)
      0:       t = '{4, lvl, 0};
      1:       t = '{4 - lvl, 4, 0};
      2:       t = '{0, 4, lvl};
      3:       t = '{0, 4 - lvl, 4};
      4:       t = '{lvl, 0, 4};
      default: t = '{4, 0, 4 - lvl};
    endcase
    return t[ch];
  endfunction

  function automatic logic [2:0] smooth_pins();
    int pwm, lvl, hue;
    logic [2:0] p;
    pwm = e % 4;
    lvl = (c / 3) % 4;
    hue = (c / 12) % 6;
    for (int ch = 0; ch < 3; ch++) begin
      p[2 - ch] = !(pwm < smooth_duty(hue, ch, lvl));
    end
    return p;
  endfunction

  task automatic check_now(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Drive one clock of stimulus and queue the pins expected after the edge.
  task automatic auto_step(input bit m, input bit pz);
    logic [2:0] x;
    string nm;
    if (!m) begin
      x  = named[(c / 12) % 6];
      nm = "hard_colour";
    end else if ((c % 12) < 3) begin
      x  = named[(c / 12) % 6];
      nm = "smooth_lvl0";
    end else begin
      x  = smooth_pins();
      nm = "smooth_fade";
    end
    mode  = m;
    pause = pz;
    @(posedge clk);
    #1;
    q.push_back('{nm, x});
    e++;
    if (!pz) c++;
  endtask

  // Monitor: pins are presented every clock; compare away from the edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      sb_t s;
      s = q.pop_front();
      checks++;
      if ({RGB_R, RGB_G, RGB_B} !== s.exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b e=%0d c=%0d", s.name,
                 {RGB_R, RGB_G, RGB_B}, s.exp, e, c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r_dark;
    int b_lit;

    // Asynchronous reset asserted between edges.
    #3 rst_n = 1'b0;
    #1 check_now("reset_async", {RGB_R, RGB_G, RGB_B}, 3'b011);
    repeat (3) @(posedge clk);
    #1 check_now("reset_hold", {RGB_R, RGB_G, RGB_B}, 3'b011);
    rst_n = 1'b0;
    e = 0; c = 0;
    rst_n = 1'b1;

    // Smooth fade through a full hue cycle; R must stay lit during RED.
    r_dark = 0;
    for (int i = 0; i < 72; i++) begin
      auto_step(1'b1, 1'b0);
      if (i < 12 && RGB_R !== 1'b0) r_dark++;
    end
    check_now("red_sector_r_dark", r_dark, 0);

    // Advance into GREEN at level 2, then pause.
    repeat (30) auto_step(1'b1, 1'b0);
    b_lit = 0;
    for (int i = 0; i < 50; i++) begin
      auto_step(1'b1, 1'b1);
      if (i < 48 && RGB_B === 1'b0) b_lit++;
    end
    check_now("pause_b_duty", b_lit, 24);
    repeat (6) auto_step(1'b1, 1'b0);

    // Hard-step through every sector.
    repeat (72) auto_step(1'b0, 1'b0);

    // Smooth up to BLUE level 1, then flip to hard-step.
    for (int i = 0; i < 72 && (c % 72) != 51; i++) auto_step(1'b1, 1'b0);
    auto_step(1'b1, 1'b0);
    auto_step(1'b0, 1'b0);

    // Continue into CYAN and reset mid-cycle.
    for (int i = 0; i < 80 && (c % 72) != 40; i++) auto_step(1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_now("reset_mid_cyan", {RGB_R, RGB_G, RGB_B}, 3'b011);
    repeat (2) @(posedge clk);
    #1 check_now("reset_mid_hold", {RGB_R, RGB_G, RGB_B}, 3'b011);
    e = 0; c = 0;
    rst_n = 1'b1;
    repeat (14) auto_step(1'b1, 1'b0);

    @(negedge clk);
    #1 check_now("scoreboard_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
